wb_retire_stage: RTL and testbench

WB_RETIRE_STAGE -- requirements
Module: wb_retire_stage

---
 rtl/wb_retire_stage_pkg.sv | 50 +++++
 rtl/wb_retire_stage_trace.sv | 49 ++++
 rtl/wb_retire_stage.sv | 142 ++++++++++++++
 tb/tb_wb_retire_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_retire_stage_pkg.sv
// Shared writeback-stage types: IO->WB payload, CP0 and ID back-pass buses,
// plus the lane bundle and lane mask used inside the multi-lane retire stage.
package wb_stage_params;
  localparam int WB_LANES     = 2;
  localparam int WB_MAX_LANES = 4;
  localparam int WB_WORD      = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic               register_file_write_enabled;
    logic [4:0]         register_file_write_address;
    logic [3:0]         register_file_write_strobe;
    logic [WB_WORD-1:0] register_file_write_data;
    logic               exception_valid;
    logic [4:0]         exception_code;
    logic               in_delay_slot;
    logic               eret_flush;
    logic               move_to_cp0;
    logic [7:0]         cp0_address;
    logic [31:0]        cp0_write_data;
  } IOToWBData;

  typedef struct packed {
    logic        exception_valid;
    logic [4:0]  exception_code;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic        eret_flush;
    logic        write_enabled;
    logic [7:0]  write_address;
    logic [31:0] write_data;
  } WBToCP0Data;

  typedef struct packed {
    logic               valid;
    logic               write_enabled;
    logic [4:0]         write_address;
    logic [WB_WORD-1:0] write_data;
  } WBToIDBackPassData;

  typedef logic [WB_MAX_LANES-1:0]      WBLaneMask;
  typedef IOToWBData [WB_MAX_LANES-1:0] WBLaneBundle;

  function automatic logic [2:0] lane_count(input WBLaneMask m);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < WB_MAX_LANES; i++) n = n + {2'b00, m[i]};
    return n;
  endfunction
endpackage

// File: rtl/wb_retire_stage_trace.sv
// Trace serializer: walks the retiring lanes of the held bundle one per cycle
// and reports done on the last one (or at once when nothing retires).
module wb_trace_serializer
  import wb_stage_params::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_valid,
  input  WBLaneMask             i_retire,
  input  WBLaneBundle           i_lanes,
  output logic [31:0]           o_pc,
  output logic [3:0]            o_we,
  output logic [4:0]            o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_done
);
  logic [1:0] r_lane;
  logic [2:0] w_count;
  IOToWBData  w_cur;
  logic       w_unused_lanes;

  // Retiring lanes always form a prefix from lane 0, so the counter is the lane index.
  assign w_count        = lane_count(i_retire);
  assign w_cur          = i_lanes[r_lane];
  assign w_unused_lanes = ^i_lanes;

  always_comb begin
    o_done = i_valid && (w_count == 3'd0 || {1'b0, r_lane} == w_count - 3'd1);
    o_pc   = '0;
    o_we   = '0;
    o_addr = '0;
    o_data = '0;
    if (i_valid) begin
      o_pc = (w_count == 3'd0) ? i_lanes[0].pc : w_cur.pc;
      if (w_count != 3'd0) begin
        o_we   = {4{w_cur.register_file_write_enabled}} & w_cur.register_file_write_strobe;
        o_addr = w_cur.register_file_write_address;
        o_data = DATA_WIDTH'(w_cur.register_file_write_data);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !i_valid || o_done) r_lane <= '0;
    else                             r_lane <= r_lane + 2'd1;
  end
endmodule

// File: rtl/wb_retire_stage.sv
// Multi-lane writeback/retire stage: holds one bundle, writes the register
// file and CP0 in its first cycle, then serializes retiring lanes to the trace port.
module wb_retire_stage
  import wb_stage_params::*;
#(
  parameter int LANES      = WB_LANES,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                io_valid,
  input  logic [LANES-1:0]                    io_lane_valid,
  input  IOToWBData [LANES-1:0]               io_lane_data,
  output logic                                wb_allow_in,
  output logic                                wb_flush,
  output logic [LANES-1:0]                    rf_write_enabled,
  output logic [LANES-1:0][4:0]               rf_write_address,
  output logic [LANES-1:0][3:0]               rf_write_strobe,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    rf_write_data,
  output WBToIDBackPassData [LANES-1:0]       wb_to_id_back_pass_bus,
  output WBToCP0Data                          wb_to_cp0_data_bus,
  output logic [31:0]                         debug_program_count,
  output logic [3:0]                          debug_register_file_write_enabled,
  output logic [4:0]                          debug_register_file_write_address,
  output logic [DATA_WIDTH-1:0]               debug_register_file_write_data
);
  logic        r_wb_valid, r_first;
  WBLaneMask   r_lane_valid;
  WBLaneBundle r_lanes;

  WBLaneMask   w_in_valid, w_exc, w_live, w_retire;
  WBLaneBundle w_in_lanes;
  IOToWBData   w_exc_lane, w_mtc0_lane;
  logic        w_valid, w_first, w_accept, w_ready_go;
  logic        w_older, w_has_exc, w_has_mtc0;

  for (genvar g = 0; g < WB_MAX_LANES; g++) begin : g_in
    if (g < LANES) begin : g_used
      assign w_in_valid[g] = io_lane_valid[g];
      assign w_in_lanes[g] = io_lane_data[g];
    end else begin : g_pad
      assign w_in_valid[g] = 1'b0;
      assign w_in_lanes[g] = '0;
    end
  end

  // Reset gates the held bundle combinationally so nothing leaks out during reset.
  assign w_valid     = r_wb_valid && !reset;
  assign w_first     = r_first && w_valid;
  assign wb_allow_in = !w_valid || w_ready_go;
  assign w_accept    = io_valid && wb_allow_in;
  assign wb_flush    = w_first && w_has_exc;
  assign w_retire    = w_live & ~w_exc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_first    <= 1'b0;
    end else if (w_accept) begin
      r_wb_valid <= !wb_flush;
      r_first    <= !wb_flush;
    end else begin
      if (w_ready_go) r_wb_valid <= 1'b0;
      r_first <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lane_valid <= w_in_valid;
      r_lanes      <= w_in_lanes;
    end
  end

  // The first excepting lane kills every younger lane.
  always_comb begin
    w_exc       = '0;
    w_live      = '0;
    w_older     = 1'b0;
    w_has_exc   = 1'b0;
    w_exc_lane  = '0;
    w_has_mtc0  = 1'b0;
    w_mtc0_lane = '0;
    for (int i = 0; i < WB_MAX_LANES; i++) begin
      w_exc[i]  = r_lane_valid[i] && (r_lanes[i].exception_valid || r_lanes[i].eret_flush);
      w_live[i] = w_valid && r_lane_valid[i] && !w_older;
      if (w_live[i] && w_exc[i]) begin
        w_has_exc  = 1'b1;
        w_exc_lane = r_lanes[i];
      end
      if (w_live[i] && !w_exc[i] && r_lanes[i].move_to_cp0) begin
        w_has_mtc0  = 1'b1;
        w_mtc0_lane = r_lanes[i];
      end
      w_older = w_older || w_exc[i];
    end
  end

  always_comb begin
    wb_to_cp0_data_bus = '0;
    if (w_first && w_has_exc) begin
      wb_to_cp0_data_bus.exception_valid = w_exc_lane.exception_valid;
      wb_to_cp0_data_bus.exception_code  = w_exc_lane.exception_code;
      wb_to_cp0_data_bus.pc              = w_exc_lane.pc;
      wb_to_cp0_data_bus.in_delay_slot   = w_exc_lane.in_delay_slot;
      wb_to_cp0_data_bus.eret_flush      = w_exc_lane.eret_flush;
    end
    if (w_first && w_has_mtc0) begin
      wb_to_cp0_data_bus.write_enabled = 1'b1;
      wb_to_cp0_data_bus.write_address = w_mtc0_lane.cp0_address;
      wb_to_cp0_data_bus.write_data    = w_mtc0_lane.cp0_write_data;
    end
  end

  // Lanes are presented in index order; the RF write port applies higher lanes last.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign rf_write_enabled[g] = w_first && w_live[g] &&
                                 r_lanes[g].register_file_write_enabled && !r_lanes[g].exception_valid;
    assign rf_write_address[g] = r_lanes[g].register_file_write_address;
    assign rf_write_strobe[g]  = r_lanes[g].register_file_write_strobe;
    assign rf_write_data[g]    = DATA_WIDTH'(r_lanes[g].register_file_write_data);
    assign wb_to_id_back_pass_bus[g] = '{
      valid:         w_valid && r_lane_valid[g],
      write_enabled: w_live[g] && r_lanes[g].register_file_write_enabled && !r_lanes[g].exception_valid,
      write_address: r_lanes[g].register_file_write_address,
      write_data:    r_lanes[g].register_file_write_data
    };
  end

  wb_trace_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_trace (
    .clock    (clock),
    .reset    (reset),
    .i_valid  (w_valid),
    .i_retire (w_retire),
    .i_lanes  (r_lanes),
    .o_pc     (debug_program_count),
    .o_we     (debug_register_file_write_enabled),
    .o_addr   (debug_register_file_write_address),
    .o_data   (debug_register_file_write_data),
    .o_done   (w_ready_go)
  );
endmodule

// File: tb/tb_wb_retire_stage.sv
// Randomized + directed bench for wb_retire_stage (LANES=2 and LANES=1 instances)
// checked against a bundle-level reference model.
module tb_wb_retire_stage;
  import wb_stage_params::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                    io_valid = 1'b0, io_valid1 = 1'b0;
  logic [1:0]              io_lane_valid = '0;
  logic [0:0]              io_lane_valid1 = '0;
  IOToWBData [1:0]         io_lane_data = '0;
  IOToWBData [0:0]         io_lane_data1 = '0;

  logic                    allow2, flush2, allow1, flush1;
  logic [1:0]              rfwe2;
  logic [1:0][4:0]         rfa2;
  logic [1:0][3:0]         rfs2;
  logic [1:0][31:0]        rfd2;
  WBToIDBackPassData [1:0] bp2;
  WBToCP0Data              cp02, cp01;
  logic [31:0]             dpc2, dpc1, dwd2, dwd1;
  logic [3:0]              dwe2, dwe1;
  logic [4:0]              dwa2, dwa1;
  logic [0:0]              rfwe1;
  logic [0:0][4:0]         rfa1;
  logic [0:0][3:0]         rfs1;
  logic [0:0][31:0]        rfd1;
  WBToIDBackPassData [0:0] bp1;

  wb_retire_stage #(.LANES(2), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .io_valid(io_valid), .io_lane_valid(io_lane_valid),
    .io_lane_data(io_lane_data), .wb_allow_in(allow2), .wb_flush(flush2),
    .rf_write_enabled(rfwe2), .rf_write_address(rfa2), .rf_write_strobe(rfs2),
    .rf_write_data(rfd2), .wb_to_id_back_pass_bus(bp2), .wb_to_cp0_data_bus(cp02),
    .debug_program_count(dpc2), .debug_register_file_write_enabled(dwe2),
    .debug_register_file_write_address(dwa2), .debug_register_file_write_data(dwd2));

  wb_retire_stage #(.LANES(1), .DATA_WIDTH(32)) dut1 (
    .clock(clock), .reset(reset), .io_valid(io_valid1), .io_lane_valid(io_lane_valid1),
    .io_lane_data(io_lane_data1), .wb_allow_in(allow1), .wb_flush(flush1),
    .rf_write_enabled(rfwe1), .rf_write_address(rfa1), .rf_write_strobe(rfs1),
    .rf_write_data(rfd1), .wb_to_id_back_pass_bus(bp1), .wb_to_cp0_data_bus(cp01),
    .debug_program_count(dpc1), .debug_register_file_write_enabled(dwe1),
    .debug_register_file_write_address(dwa1), .debug_register_file_write_data(dwd1));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the held bundle and how many cycles it has been held.
  int          sel = 0;
  logic        m_held = 1'b0;
  int          m_k = 0, m_nv = 0;
  IOToWBData   m_l [2];
  logic [31:0] rf_obs [32];
  logic [36:0] tr_q [$];
  logic [31:0] cp0_exc_pc, cp0_eret_pc;
  logic [4:0]  cp0_exc_code;
  int          n_flush = 0;

  // Observed outputs, widened to two lanes.
  logic o_allow, o_flush;
  logic [1:0] o_we, o_bpv;
  logic [1:0][4:0] o_a;
  logic [1:0][3:0] o_s;
  logic [1:0][31:0] o_d;
  WBToCP0Data o_cp0;
  logic [31:0] o_dpc, o_dwd;
  logic [3:0] o_dwe;
  logic [4:0] o_dwa;

  task automatic sample();
    if (sel == 0) begin
      o_allow = allow2; o_flush = flush2; o_we = rfwe2; o_a = rfa2; o_s = rfs2; o_d = rfd2;
      o_bpv = {bp2[1].valid, bp2[0].valid}; o_cp0 = cp02;
      o_dpc = dpc2; o_dwe = dwe2; o_dwa = dwa2; o_dwd = dwd2;
    end else begin
      o_allow = allow1; o_flush = flush1; o_we = {1'b0, rfwe1[0]}; o_a = {5'd0, rfa1[0]};
      o_s = {4'd0, rfs1[0]}; o_d = {32'd0, rfd1[0]}; o_bpv = {1'b0, bp1[0].valid}; o_cp0 = cp01;
      o_dpc = dpc1; o_dwe = dwe1; o_dwa = dwa1; o_dwd = dwd1;
    end
  endtask

  task automatic cyc(input logic rst, input logic v, input int nv, input IOToWBData a, input IOToWBData b);
    logic held, first, ready, e_allow, e_flush, e_we, e_mw;
    int fe, nret, nl;
    logic [7:0] e_ma;
    logic [31:0] e_md;
    @(negedge clock);
    reset = rst;
    if (sel == 0) begin
      io_valid = v; io_lane_valid = (nv >= 2) ? 2'b11 : (nv == 1) ? 2'b01 : 2'b00;
      io_lane_data[0] = a; io_lane_data[1] = b;
    end else begin
      io_valid1 = v; io_lane_valid1 = (nv >= 1) ? 1'b1 : 1'b0; io_lane_data1[0] = a;
    end
    #1;
    sample();
    nl = (sel == 0) ? 2 : 1;
    held = m_held && !rst;
    fe = m_nv;
    for (int i = m_nv - 1; i >= 0; i--)
      if (m_l[i].exception_valid || m_l[i].eret_flush) fe = i;
    nret = fe;
    first = (m_k == 0);
    ready = held && (nret == 0 || m_k == nret - 1);
    e_allow = !held || ready;
    e_flush = held && first && (fe < m_nv);
    chk("allow_in", o_allow, e_allow);
    chk("wb_flush", o_flush, e_flush);
    for (int i = 0; i < nl; i++) begin
      e_we = held && first && i < m_nv && i <= fe &&
             m_l[i].register_file_write_enabled && !m_l[i].exception_valid;
      chk("rf_we", o_we[i], e_we);
      chk("bp_valid", o_bpv[i], held && i < m_nv);
      if (e_we) begin
        chk("rf_addr", o_a[i], m_l[i].register_file_write_address);
        chk("rf_strb", o_s[i], m_l[i].register_file_write_strobe);
        chk("rf_data", o_d[i], m_l[i].register_file_write_data);
      end
    end
    chk("cp0_exc", o_cp0.exception_valid, e_flush && m_l[fe].exception_valid);
    chk("cp0_eret", o_cp0.eret_flush, e_flush && m_l[fe].eret_flush);
    if (e_flush) begin
      chk("cp0_pc", o_cp0.pc, m_l[fe].pc);
      chk("cp0_code", o_cp0.exception_code, m_l[fe].exception_code);
      chk("cp0_ds", o_cp0.in_delay_slot, m_l[fe].in_delay_slot);
    end
    e_mw = 1'b0; e_ma = '0; e_md = '0;
    for (int i = 0; i < fe; i++)
      if (m_l[i].move_to_cp0) begin e_mw = held && first; e_ma = m_l[i].cp0_address; e_md = m_l[i].cp0_write_data; end
    chk("cp0_we", o_cp0.write_enabled, e_mw);
    if (e_mw) begin
      chk("cp0_wa", o_cp0.write_address, e_ma);
      chk("cp0_wd", o_cp0.write_data, e_md);
    end
    if (held) begin
      chk("dbg_pc", o_dpc, (nret == 0) ? m_l[0].pc : m_l[m_k].pc);
      chk("dbg_we", o_dwe, (nret == 0) ? 4'h0 :
          ({4{m_l[m_k].register_file_write_enabled}} & m_l[m_k].register_file_write_strobe));
      if (nret != 0 && o_dwe != 4'h0) begin
        chk("dbg_addr", o_dwa, m_l[m_k].register_file_write_address);
        chk("dbg_data", o_dwd, m_l[m_k].register_file_write_data);
      end
    end else chk("dbg_we_idle", o_dwe, 4'h0);
    // Observed side effects for the directed checks.
    for (int i = 0; i < nl; i++) if (o_we[i]) rf_obs[o_a[i]] = o_d[i];
    if (o_dwe != 4'h0) tr_q.push_back({o_dwa, o_dwd});
    if (o_cp0.exception_valid) begin cp0_exc_pc = o_cp0.pc; cp0_exc_code = o_cp0.exception_code; end
    if (o_cp0.eret_flush) cp0_eret_pc = o_cp0.pc;
    if (o_flush) n_flush++;
    if (rst) begin m_held = 1'b0; m_k = 0; end
    else if (v && e_allow) begin m_held = !e_flush; m_k = 0; m_nv = nv; m_l[0] = a; m_l[1] = b; end
    else if (held && ready) begin m_held = 1'b0; m_k = 0; end
    else if (held) m_k++;
  endtask

  function automatic IOToWBData mk(input logic [31:0] pc, input logic we, input logic [4:0] ra, input logic [31:0] d);
    IOToWBData x;
    x = '0; x.pc = pc; x.register_file_write_enabled = we; x.register_file_write_address = ra;
    x.register_file_write_strobe = 4'hF; x.register_file_write_data = d;
    return x;
  endfunction

  function automatic IOToWBData rnd_lane();
    IOToWBData x;
    x = '0;
    x.pc = $urandom() & 32'hFFFF_FFFC;
    x.register_file_write_enabled = ($urandom_range(0, 3) != 0);
    x.register_file_write_address = 5'($urandom_range(0, 31));
    x.register_file_write_strobe = 4'($urandom_range(0, 15));
    x.register_file_write_data = $urandom();
    x.exception_valid = ($urandom_range(0, 9) == 0);
    x.exception_code = 5'($urandom_range(0, 31));
    x.in_delay_slot = 1'($urandom_range(0, 1));
    x.eret_flush = !x.exception_valid && ($urandom_range(0, 11) == 0);
    x.cp0_address = 8'($urandom_range(0, 255));
    x.cp0_write_data = $urandom();
    return x;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, '0, '0);
  endtask

  IOToWBData ta, tb2;
  int nv, mlane;

  initial begin
    for (int i = 0; i < 32; i++) rf_obs[i] = 32'hDEADBEEF;
    cp0_exc_pc = '0; cp0_eret_pc = '0; cp0_exc_code = '0;
    cyc(1'b1, 1'b0, 0, '0, '0);
    cyc(1'b1, 1'b0, 0, '0, '0);
    idle(1);

    // Two lanes both writing.
    tr_q.delete();
    cyc(1'b0, 1'b1, 2, mk(32'h100, 1'b1, 5'd3, 32'h11), mk(32'h104, 1'b1, 5'd4, 32'h22));
    idle(3);
    chk("t1_r3", rf_obs[3], 32'h11);
    chk("t1_r4", rf_obs[4], 32'h22);
    chk("t1_ntr", tr_q.size(), 2);
    if (tr_q.size() == 2) begin
      chk("t1_tr0", tr_q[0], {5'd3, 32'h11});
      chk("t1_tr1", tr_q[1], {5'd4, 32'h22});
    end

    // Lane 0 exception; the bundle right behind it is dropped.
    ta = mk(32'h200, 1'b0, 5'd0, 32'h0); ta.exception_valid = 1'b1; ta.exception_code = 5'h0C;
    n_flush = 0; tr_q.delete();
    cyc(1'b0, 1'b1, 2, ta, mk(32'h204, 1'b1, 5'd5, 32'h55));
    cyc(1'b0, 1'b1, 1, mk(32'h300, 1'b1, 5'd9, 32'h99), '0);
    idle(3);
    chk("t2_r5", rf_obs[5], 32'hDEADBEEF);
    chk("t2_r9", rf_obs[9], 32'hDEADBEEF);
    chk("t2_pc", cp0_exc_pc, 32'h200);
    chk("t2_code", cp0_exc_code, 5'h0C);
    chk("t2_flush", n_flush, 1);
    chk("t2_ntr", tr_q.size(), 0);

    // Lane 1 eret after a writing lane 0.
    tb2 = mk(32'h404, 1'b0, 5'd0, 32'h0); tb2.eret_flush = 1'b1;
    n_flush = 0; tr_q.delete();
    cyc(1'b0, 1'b1, 2, mk(32'h400, 1'b1, 5'd6, 32'h7), tb2);
    idle(3);
    chk("t3_r6", rf_obs[6], 32'h7);
    chk("t3_eret_pc", cp0_eret_pc, 32'h404);
    chk("t3_flush", n_flush, 1);
    chk("t3_ntr", tr_q.size(), 1);

    // Same destination in both lanes.
    tr_q.delete();
    cyc(1'b0, 1'b1, 2, mk(32'h500, 1'b1, 5'd8, 32'hA), mk(32'h504, 1'b1, 5'd8, 32'hB));
    idle(3);
    chk("t4_r8", rf_obs[8], 32'hB);
    chk("t4_ntr", tr_q.size(), 2);
    if (tr_q.size() == 2) begin
      chk("t4_tr0", tr_q[0][31:0], 32'hA);
      chk("t4_tr1", tr_q[1][31:0], 32'hB);
    end

    // Reset in the second trace cycle.
    tr_q.delete();
    cyc(1'b0, 1'b1, 2, mk(32'h600, 1'b1, 5'd10, 32'h1), mk(32'h604, 1'b1, 5'd11, 32'h2));
    idle(1);
    cyc(1'b1, 1'b0, 0, '0, '0);
    idle(2);
    chk("t5_ntr", tr_q.size(), 1);
    chk("t5_allow", allow2, 1'b1);

    // Random traffic, two lanes.
    for (int c = 0; c < 400; c++) begin
      ta = rnd_lane(); tb2 = rnd_lane(); nv = $urandom_range(1, 2); mlane = $urandom_range(0, 3);
      if (mlane == 0) ta.move_to_cp0 = 1'b1;
      if (mlane == 1 && nv == 2) tb2.move_to_cp0 = 1'b1;
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), nv, ta, tb2);
    end

    // Single-lane instance: back-to-back retires, never stalls.
    sel = 1;
    cyc(1'b1, 1'b0, 0, '0, '0);
    tr_q.delete();
    for (int c = 0; c < 4; c++)
      cyc(1'b0, 1'b1, 1, mk(32'h700 + 32'(4 * c), 1'b1, 5'(12 + c), 32'(c + 1)), '0);
    idle(2);
    chk("t6_ntr", tr_q.size(), 4);
    chk("t6_r15", rf_obs[15], 32'h4);
    for (int c = 0; c < 200; c++) begin
      ta = rnd_lane(); ta.move_to_cp0 = ($urandom_range(0, 3) == 0);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1, ta, '0);
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
